// File: rtl/resadd_pkg.sv
// rtl/resadd_pkg.sv - shared constants, lane vector type and int8 requantization helpers
package resadd_pkg;

  localparam int LANES = 32;
  localparam int BEATS = 4;
  localparam int DW    = 8;
  localparam int MW    = 32;
  localparam int FRAC  = 16;

  // 8b signed x 32b unsigned product, and the sum of two of them
  localparam int PW = DW + MW + 1;
  localparam int SW = PW + 1;

  // beat index width and the index of the final beat in a token
  localparam int BW = 2;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  // width of a per-beat clipped-lane count (0..LANES)
  localparam int CW = $clog2(LANES + 1);

  localparam int INT8_MAX = 127;
  localparam int INT8_MIN = -128;

  localparam logic signed [SW-1:0] SAT_HI = SW'(INT8_MAX);
  localparam logic signed [SW-1:0] SAT_LO = SW'(INT8_MIN);

  typedef logic [LANES*DW-1:0] lane_vec_t;

  // floor-shift the Q.FRAC sum back to integer and clamp to int8
  function automatic logic [DW-1:0] sat_int8(input logic signed [SW-1:0] sum);
    logic signed [SW-1:0] y;
    y = sum >>> FRAC;
    if (y > SAT_HI) begin
      return 8'h7F;
    end else if (y < SAT_LO) begin
      return 8'h80;
    end else begin
      return y[DW-1:0];
    end
  endfunction

  // true when sat_int8 would clamp this sum
  function automatic logic is_clip(input logic signed [SW-1:0] sum);
    logic signed [SW-1:0] y;
    y = sum >>> FRAC;
    return (y > SAT_HI) || (y < SAT_LO);
  endfunction

endpackage

// File: rtl/resadd_lane.sv
// rtl/resadd_lane.sv - one lane: two requant multiplies, stage-1 product registers, add, floor-shift, saturate (clip flag with RESADD_SAT_STATS_EN)
module resadd_lane
  import resadd_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          s1_en,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [MW-1:0] ma,
  input  logic [MW-1:0] mb,
  output logic [DW-1:0] y
`ifdef RESADD_SAT_STATS_EN
  ,
  output logic          clip
`endif
);

  logic signed [PW-1:0] a_x;
  logic signed [PW-1:0] b_x;
  logic signed [PW-1:0] ma_x;
  logic signed [PW-1:0] mb_x;
  logic signed [PW-1:0] pa;
  logic signed [PW-1:0] pb;
  logic signed [SW-1:0] sum;

  // sign-extend the int8 operands, zero-extend the unsigned multipliers
  assign a_x  = PW'($signed(a));
  assign b_x  = PW'($signed(b));
  assign ma_x = PW'({1'b0, ma});
  assign mb_x = PW'({1'b0, mb});

  // stage 1: capture both products when a beat is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      pa <= '0;
      pb <= '0;
    end else if (s1_en) begin
      pa <= a_x * ma_x;
      pb <= b_x * mb_x;
    end
  end

  // stage 2 combinational part; the top registers the result
  assign sum = SW'(pa) + SW'(pb);
  assign y   = sat_int8(sum);

`ifdef RESADD_SAT_STATS_EN
  assign clip = is_clip(sum);
`endif

endmodule

// File: rtl/residual_add_requant.sv
// rtl/residual_add_requant.sv - joins sub-layer and residual int8 beats, requantized residual add to int8; optional RESADD_SAT_STATS_EN adds sat_count
module residual_add_requant
  import resadd_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [LANES*DW-1:0]   a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [LANES*DW-1:0]   b_data,
  input  logic [MW-1:0]         a_mult,
  input  logic [MW-1:0]         b_mult,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*DW-1:0]   out_data,
  output logic                  out_last
`ifdef RESADD_SAT_STATS_EN
  ,
  output logic [15:0]           sat_count
`endif
);

  logic          in_ready;
  logic          fire;
  logic          s2_en;
  logic          s2_load;
  logic          s1_valid;
  logic [BW-1:0] beat_cnt;
  logic [BW-1:0] s1_beat;
  logic [MW-1:0] ma_lat;
  logic [MW-1:0] mb_lat;
  logic [MW-1:0] ma_eff;
  logic [MW-1:0] mb_eff;
  lane_vec_t     y_vec;

  // output register frees when empty or draining; stage 1 frees when empty or moving on
  assign s2_en    = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_en;
  assign fire     = a_valid && b_valid && in_ready;
  assign s2_load  = s2_en && s1_valid;

  // both streams are consumed together or not at all
  assign a_ready = fire;
  assign b_ready = fire;

  // beat 0 uses the live multipliers; later beats reuse what beat 0 latched
  assign ma_eff = (beat_cnt == '0) ? a_mult : ma_lat;
  assign mb_eff = (beat_cnt == '0) ? b_mult : mb_lat;

  // beat counter and per-token multiplier latch
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
      ma_lat   <= '0;
      mb_lat   <= '0;
    end else if (fire) begin
      beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 2'd1;
      if (beat_cnt == '0) begin
        ma_lat <= a_mult;
        mb_lat <= b_mult;
      end
    end
  end

  // stage-1 valid and the beat index travelling with the products
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_beat  <= '0;
    end else if (in_ready) begin
      s1_valid <= fire;
      if (fire) begin
        s1_beat <= beat_cnt;
      end
    end
  end

`ifdef RESADD_SAT_STATS_EN
  logic [LANES-1:0] clip_vec;
`endif

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    resadd_lane u_lane (
      .clk   (clk),
      .rst   (rst),
      .s1_en (fire),
      .a     (a_data[DW*i +: DW]),
      .b     (b_data[DW*i +: DW]),
      .ma    (ma_eff),
      .mb    (mb_eff),
      .y     (y_vec[DW*i +: DW])
`ifdef RESADD_SAT_STATS_EN
      ,
      .clip  (clip_vec[i])
`endif
    );
  end

  // stage-2 output register; holds while stalled downstream
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (s2_en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= y_vec;
        out_last <= (s1_beat == LAST_BEAT);
      end
    end
  end

`ifdef RESADD_SAT_STATS_EN
  logic [CW-1:0] clip_cnt;
  logic [CW-1:0] out_clip_cnt;
  logic [16:0]   sat_sum;

  // count the clipped lanes of the beat leaving stage 1
  always_comb begin
    clip_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      clip_cnt = clip_cnt + CW'(clip_vec[i]);
    end
  end

  // clip count rides with the beat in the output register
  always_ff @(posedge clk) begin
    if (rst) begin
      out_clip_cnt <= '0;
    end else if (s2_load) begin
      out_clip_cnt <= clip_cnt;
    end
  end

  assign sat_sum = {1'b0, sat_count} + 17'(out_clip_cnt);

  // accumulate on output handshake, sticking at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_count <= '0;
    end else if (out_valid && out_ready) begin
      sat_count <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_residual_add_requant.sv
// tb/tb_residual_add_requant.sv - scoreboard bench for residual_add_requant (sat_count checked with RESADD_SAT_STATS_EN)
module tb_residual_add_requant;

  logic         clk;
  logic         rst;
  logic         a_valid;
  logic         a_ready;
  logic [255:0] a_data;
  logic         b_valid;
  logic         b_ready;
  logic [255:0] b_data;
  logic [31:0]  a_mult;
  logic [31:0]  b_mult;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_data;
  logic         out_last;
`ifdef RESADD_SAT_STATS_EN
  logic [15:0]  sat_count;
`endif

  residual_add_requant dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_data    (a_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_data    (b_data),
    .a_mult    (a_mult),
    .b_mult    (b_mult),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
`ifdef RESADD_SAT_STATS_EN
    ,
    .sat_count (sat_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [255:0] data;
    logic         last;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          m_beat  = 0;
  logic [31:0] m_ma    = '0;
  logic [31:0] m_mb    = '0;

  function automatic logic [255:0] rep(input logic [7:0] v);
    return {32{v}};
  endfunction

  function automatic logic [255:0] rand_vec();
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[8*i +: 8] = 8'($urandom);
    return r;
  endfunction

  function automatic logic [255:0] model_beat(input logic [255:0] a, input logic [255:0] b,
                                              input logic [31:0] ma, input logic [31:0] mb);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) begin
      longint av, bv, p, y;
      av = longint'($signed(a[8*i +: 8]));
      bv = longint'($signed(b[8*i +: 8]));
      p  = av * longint'(ma) + bv * longint'(mb);
      y  = p >>> 16;
      if (y > 127)       r[8*i +: 8] = 8'h7F;
      else if (y < -128) r[8*i +: 8] = 8'h80;
      else               r[8*i +: 8] = y[7:0];
    end
    return r;
  endfunction

  task automatic push_fire(input logic [255:0] a, input logic [255:0] b,
                           input logic [31:0] ma, input logic [31:0] mb);
    exp_t e;
    if (m_beat == 0) begin
      m_ma = ma;
      m_mb = mb;
    end
    e.data = model_beat(a, b, m_ma, m_mb);
    e.last = (m_beat == 3);
    exp_q.push_back(e);
    m_beat = (m_beat + 1) % 4;
  endtask

  task automatic send_beat(input logic [255:0] a, input logic [255:0] b,
                           input logic [31:0] ma, input logic [31:0] mb, output int waited);
    bit ok;
    ok = 0;
    waited = 0;
    a_valid = 1'b1; b_valid = 1'b1;
    a_data = a; b_data = b; a_mult = ma; b_mult = mb;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      if (a_ready) begin
        push_fire(a, b, ma, mb);
        ok = 1;
      end else begin
        waited++;
      end
      @(posedge clk); #1;
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL send_beat_timeout got a_ready=0 for 200 cycles, expected handshake");
    end
  endtask

  task automatic idle();
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout got %0d beats outstanding, expected 0", exp_q.size());
    end
  endtask

  // scoreboard: compare every output handshake with the next expected beat
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_beat got data=%h last=%b, expected no beat", out_data, out_last);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e.data || out_last !== e.last) begin
          n_fail++;
          $display("FAIL scoreboard_beat got data=%h last=%b expected data=%h last=%b",
                   out_data, out_last, e.data, e.last);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
    n_tests++;
    if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last got %b expected 0", out_last); end
    n_tests++;
    if (out_data !== 256'd0) begin n_fail++; $display("FAIL reset_out_data got %h expected 0", out_data); end
`ifdef RESADD_SAT_STATS_EN
    n_tests++;
    if (sat_count !== 16'd0) begin n_fail++; $display("FAIL reset_sat_count got %0d expected 0", sat_count); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int w;
    send_beat(rep(8'd10), rep(8'hFD), 32'h0001_0000, 32'h0002_0000, w);
    n_tests++;
    if (w !== 0) begin n_fail++; $display("FAIL ready_after_reset got wait=%0d expected 0", w); end
    idle();
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL latency_t1 got out_valid=%b expected 0", out_valid); end
    @(posedge clk); #1;
    n_tests++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL latency_t2 got out_valid=%b expected 1", out_valid); end
    n_tests++;
    if (out_data !== rep(8'h04) || out_last !== 1'b0)
      begin n_fail++; $display("FAIL basic_beat0 got %h last=%b expected %h last=0", out_data, out_last, rep(8'h04)); end
    for (int i = 1; i < 4; i++) send_beat(rep(8'd10), rep(8'hFD), 32'h0001_0000, 32'h0002_0000, w);
    idle();
    drain();
  endtask

  task automatic test_floor();
    int w;
    send_beat(rep(8'd1),  rep(8'd0), 32'h0000_8000, 32'h0000_8000, w);
    send_beat(rep(8'hFF), rep(8'd0), 32'h0000_8000, 32'h0000_8000, w);
    send_beat(rand_vec(), rand_vec(), 32'h0000_8000, 32'h0000_8000, w);
    send_beat(rand_vec(), rand_vec(), 32'h0000_8000, 32'h0000_8000, w);
    idle();
    drain();
  endtask

  task automatic test_saturation();
    int w;
    logic [15:0] base;
`ifdef RESADD_SAT_STATS_EN
    base = sat_count;
`else
    base = '0;
`endif
    send_beat(rep(8'd127), rep(8'd127), 32'h0002_0000, 32'h0001_0000, w);
    send_beat(rep(8'h80),  rep(8'h80),  32'h0002_0000, 32'h0001_0000, w);
    send_beat(rep(8'd0),   rep(8'd0),   32'h0002_0000, 32'h0001_0000, w);
    send_beat(rep(8'd0),   rep(8'd0),   32'h0002_0000, 32'h0001_0000, w);
    idle();
    drain();
    @(posedge clk); #1;
`ifdef RESADD_SAT_STATS_EN
    n_tests++;
    if (sat_count !== base + 16'd64)
      begin n_fail++; $display("FAIL sat_count got %0d expected %0d", sat_count, base + 16'd64); end
`else
    if (base != 0) $display("base unused");
`endif
  endtask

  task automatic test_backpressure();
    logic [255:0] ta[4];
    logic [255:0] tb_d[4];
    logic [31:0]  ma, mb;
    logic [255:0] held;
    logic         held_last;
    int           idx;
    for (int i = 0; i < 4; i++) begin ta[i] = rand_vec(); tb_d[i] = rand_vec(); end
    ma = 32'($urandom_range(0, 32'h0002_FFFF));
    mb = 32'($urandom_range(0, 32'h0002_FFFF));
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      a_valid = 1'b1; b_valid = 1'b1;
      a_data = ta[idx]; b_data = tb_d[idx]; a_mult = ma; b_mult = mb;
      @(negedge clk);
      if (a_ready) begin push_fire(ta[idx], tb_d[idx], ma, mb); idx++; end
      @(posedge clk); #1;
    end
    n_tests++;
    if (idx !== 2) begin n_fail++; $display("FAIL stall_fire_count got %0d expected 2", idx); end
    a_data = ta[idx]; b_data = tb_d[idx];
    @(negedge clk);
    n_tests++;
    if (a_ready !== 1'b0) begin n_fail++; $display("FAIL stall_a_ready got %b expected 0", a_ready); end
    held = out_data;
    held_last = out_last;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== held || out_last !== held_last)
        begin n_fail++; $display("FAIL stall_stable got valid=%b data=%h expected valid=1 data=%h", out_valid, out_data, held); end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int c = 0; c < 50 && idx < 4; c++) begin
      a_data = ta[idx]; b_data = tb_d[idx];
      @(negedge clk);
      if (a_ready) begin push_fire(ta[idx], tb_d[idx], ma, mb); idx++; end
      @(posedge clk); #1;
    end
    idle();
    n_tests++;
    if (idx !== 4) begin n_fail++; $display("FAIL stall_resume got %0d fires expected 4", idx); end
    drain();
  endtask

  task automatic test_join_skew();
    int w;
    logic [255:0] a0, b0;
    a0 = rand_vec(); b0 = rand_vec();
    a_valid = 1'b1; b_valid = 1'b0;
    a_data = a0; b_data = b0; a_mult = 32'h0001_8000; b_mult = 32'h0000_C000;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_tests++;
      if (a_ready !== 1'b0 || b_ready !== 1'b0)
        begin n_fail++; $display("FAIL skew_ready got a=%b b=%b expected 0 0", a_ready, b_ready); end
      @(posedge clk); #1;
    end
    send_beat(a0, b0, 32'h0001_8000, 32'h0000_C000, w);
    n_tests++;
    if (w !== 0) begin n_fail++; $display("FAIL skew_fire got wait=%0d expected 0", w); end
    for (int i = 1; i < 4; i++) send_beat(rand_vec(), rand_vec(), 32'h0001_8000, 32'h0000_C000, w);
    idle();
    drain();
  endtask

  task automatic test_back_to_back();
    int w;
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < 4; i++) begin
        // mid-token multiplier change from beat 2 must be ignored
        send_beat(rep(8'd20), rep(8'd5),
                  (i < 2) ? 32'h0001_0000 + 32'(t) * 32'h0001_0000 : 32'h0003_0000,
                  32'h0001_0000, w);
        n_tests++;
        if (w !== 0) begin n_fail++; $display("FAIL b2b_bubble token %0d beat %0d got wait=%0d expected 0", t, i, w); end
      end
    end
    idle();
    drain();
  endtask

  task automatic test_mid_reset();
    int w;
    send_beat(rand_vec(), rand_vec(), 32'h0001_0000, 32'h0001_0000, w);
    send_beat(rand_vec(), rand_vec(), 32'h0001_0000, 32'h0001_0000, w);
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    m_beat = 0;
    n_tests++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 256'd0)
      begin n_fail++; $display("FAIL mid_reset_clear got valid=%b last=%b data=%h expected 0", out_valid, out_last, out_data); end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(rand_vec(), rand_vec(), 32'h0000_C000, 32'h0001_4000, w);
    idle();
    drain();
  endtask

  task automatic test_random();
    int w;
    logic [31:0] ma, mb;
    for (int t = 0; t < 3; t++) begin
      ma = 32'($urandom_range(0, 32'h0003_FFFF));
      mb = 32'($urandom_range(0, 32'h0003_FFFF));
      for (int i = 0; i < 4; i++) send_beat(rand_vec(), rand_vec(), ma, mb, w);
    end
    idle();
    drain();
  endtask

  initial begin
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b1;
    a_data = '0; b_data = '0; a_mult = '0; b_mult = '0;
    test_reset();
    test_basic();
    test_floor();
    test_saturation();
    test_backpressure();
    test_join_skew();
    test_back_to_back();
    test_mid_reset();
    test_random();
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL final_queue got %0d expected 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
